// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller: load-use stall, taken-branch flush,
//            instruction-fetch wait. Optional HAZARD_PERF_CNT_EN adds stall_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int BRANCH_PENALTY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_IWAIT   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // Cycles still owed after the branch cycle itself.
    localparam logic [2:0] c_reload_cnt = 3'(BRANCH_PENALTY - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       w_load_use;

    assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = ST_RUN;
            cnt_d        = 3'd0;
        end else if (branch_taken) begin
            // A branch during FLUSH restarts the penalty rather than adding to it.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            cnt_d        = c_reload_cnt;
            state_d      = (BRANCH_PENALTY > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (!imem_ready) begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        state_d     = ST_IWAIT;
                    end
                end
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                    pc_write    = imem_ready;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = 3'(cnt_q - 3'd1);
                    end
                end
                ST_IWAIT: begin
                    // ID holds a NOP here, so load-use is not considered.
                    if (!imem_ready) begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    pc_write     = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = ST_RUN;
                    cnt_d        = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((!pc_write || if_id_flush) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (penalties 1, 3, 5) against a
//            cycle-level behavioural model; HAZARD_PERF_CNT_EN also checks stall_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rt = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rt = '0;
    logic       branch_taken = 1'b0;
    logic       imem_ready = 1'b1;

    logic [NI-1:0] pcw, ifw, ifl, bub;
    logic [1:0]    st [NI];
    logic [31:0]   sc_dut [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    `define TB_SC(k) , .stall_cnt(sc_dut[k])
`else
    `define TB_SC(k)
    initial for (int k = 0; k < NI; k++) sc_dut[k] = '0;
`endif

    hazard_ctrl #(.BRANCH_PENALTY(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_write(pcw[0]), .if_id_write(ifw[0]),
        .if_id_flush(ifl[0]), .id_ex_bubble(bub[0]), .state(st[0]) `TB_SC(0));

    hazard_ctrl #(.BRANCH_PENALTY(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_write(pcw[1]), .if_id_write(ifw[1]),
        .if_id_flush(ifl[1]), .id_ex_bubble(bub[1]), .state(st[1]) `TB_SC(1));

    hazard_ctrl #(.BRANCH_PENALTY(5)) u_p5 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_write(pcw[2]), .if_id_write(ifw[2]),
        .if_id_flush(ifl[2]), .id_ex_bubble(bub[2]), .state(st[2]) `TB_SC(2));

    // Output patterns {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] P_RESET  = 4'b0111;
    localparam logic [3:0] P_LU     = 4'b0001;
    localparam logic [3:0] P_NORMAL = 4'b1100;
    localparam logic [3:0] P_FWAIT  = 4'b0110;
    localparam logic [3:0] P_BRANCH = 4'b1111;

    function automatic logic [3:0] outs(input int k);
        return {pcw[k], ifw[k], ifl[k], bub[k]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: owed flush cycles, fetch-wait flag, stall tally.
    int          pen [NI] = '{1, 3, 5};
    int          rem [NI] = '{0, 0, 0};
    bit          wt  [NI] = '{0, 0, 0};
    int unsigned sc  [NI] = '{0, 0, 0};

    always @(negedge clk) begin
        logic       lu;
        logic [3:0] e;
        logic [1:0] est;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                e = P_RESET; est = 2'd0; rem[k] = 0; wt[k] = 0; sc[k] = 0;
            end else begin
                est = (rem[k] > 0) ? 2'd1 : (wt[k] ? 2'd2 : 2'd0);
                if (branch_taken) begin
                    e = P_BRANCH; rem[k] = pen[k] - 1; wt[k] = 0;
                end else if (rem[k] > 0) begin
                    e = {imem_ready, 3'b110}; rem[k]--;
                end else if (!wt[k] && lu) begin
                    e = P_LU;
                end else if (!imem_ready) begin
                    e = P_FWAIT; wt[k] = 1;
                end else begin
                    e = P_NORMAL; wt[k] = 0;
                end
            end
            checks++;
            if ({outs(k), st[k]} !== {e, est}) begin
                errors++;
                $display("FAIL model[P=%0d] t=%0t: got outs=%b state=%0d expected outs=%b state=%0d",
                         pen[k], $time, outs(k), st[k], e, est);
            end
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("model stall_cnt[P=%0d]", pen[k]), sc_dut[k], sc[k]);
`endif
            if (rst_n && (!e[3] || e[1]) && sc[k] != 32'hFFFF_FFFF) sc[k]++;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br,
                         input logic rdy);
        ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        id_uses_rt = urt; branch_taken = br; imem_ready = rdy;
    endtask

    initial begin
        // Reset state
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("reset outs", 32'(outs(1)), 32'(P_RESET));
        chk("reset state", 32'(st[1]), 0);
        chk("reset stall_cnt", sc_dut[1], 0);
        nxt(); nxt(); rst_n = 1'b1;

        // Load-use on rs
        drive(1, 8, 8, 0, 0, 0, 1);
        @(negedge clk);
        chk("lu rs outs", 32'(outs(1)), 32'(P_LU));
        chk("lu rs state", 32'(st[1]), 0);
        nxt();
        // r0 never stalls
        drive(1, 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("lu r0 pc_write", 32'(pcw[1]), 1);
        nxt();
        // rt match without rt use: no stall; with rt use: stall
        drive(1, 8, 3, 8, 0, 0, 1);
        @(negedge clk);
        chk("rt unused pc_write", 32'(pcw[1]), 1);
        nxt();
        drive(1, 8, 3, 8, 1, 0, 1);
        @(negedge clk);
        chk("rt used outs", 32'(outs(1)), 32'(P_LU));
        nxt();

        // Branch pulse, penalty 3 / 1
        drive(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("br N outs", 32'(outs(1)), 32'(P_BRANCH));
        nxt(); drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("br N+1 state", 32'(st[1]), 1);
        chk("br N+1 flush/bubble", 32'({ifl[1], bub[1]}), 32'(2'b10));
        chk("br P1 N+1 state", 32'(st[0]), 0);
        nxt();
        @(negedge clk);
        chk("br N+2 state", 32'(st[1]), 1);
        chk("br N+2 flush/bubble", 32'({ifl[1], bub[1]}), 32'(2'b10));
        nxt();
        @(negedge clk);
        chk("br N+3 state", 32'(st[1]), 0);
        chk("br N+3 flush", 32'(ifl[1]), 0);
        nxt();

        // Fetch wait for 4 cycles, counted from a fresh reset
        rst_n = 1'b0; nxt(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("iwait c%0d outs", i + 1), 32'(outs(1)), 32'(P_FWAIT));
            chk($sformatf("iwait c%0d state", i + 1), 32'(st[1]), (i == 0) ? 0 : 2);
            nxt();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("iwait ready outs", 32'(outs(1)), 32'(P_NORMAL));
        nxt();
        @(negedge clk);
        chk("iwait after state", 32'(st[1]), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("iwait stall_cnt", sc_dut[1], 4);
`endif
        nxt();

        // lu + fetch-not-ready: stall wins; branch + lu: branch wins
        drive(1, 5, 5, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu+nready outs", 32'(outs(1)), 32'(P_LU));
        nxt();
        drive(1, 5, 5, 0, 0, 1, 1);
        @(negedge clk);
        chk("br+lu outs", 32'(outs(1)), 32'(P_BRANCH));
        nxt();

        // Reset during FLUSH (penalty 5)
        drive(0, 0, 0, 0, 0, 1, 1);
        nxt(); drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("p5 flush state", 32'(st[2]), 1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("p5 async reset state", 32'(st[2]), 0);
        chk("p5 async reset outs", 32'(outs(2)), 32'(P_RESET));
        nxt(); rst_n = 1'b1;
        @(negedge clk);
        chk("p5 post-reset outs", 32'(outs(2)), 32'(P_NORMAL));
        chk("p5 post-reset stall_cnt", sc_dut[2], 0);
        nxt();

        // Random traffic, register fields narrowed to provoke matches
        for (int i = 0; i < 3000; i++) begin
            ex_mem_read  = ($urandom_range(0, 1) == 1);
            ex_rt        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = ($urandom_range(0, 1) == 1);
            branch_taken = ($urandom_range(0, 7) == 0);
            imem_ready   = ($urandom_range(0, 3) != 0);
            rst_n        = ($urandom_range(0, 99) != 0);
            nxt();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        nxt(); nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: BRANCH_PENALTY, default 1, range 1..7; total IF_ID flush cycles per taken branch.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk by the upstream reset synchronizer.
REQ-004 id_rs  in  5  rs field of instruction in IF_ID.
REQ-005 id_rt  in  5  rt field of instruction in IF_ID.
REQ-006 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-007 ex_mem_read  in  1  instruction in ID_EX is a load.
REQ-008 ex_rt  in  5  destination register of load in ID_EX.
REQ-009 branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 imem_ready  in  1  instruction memory output valid this cycle.
REQ-011 pc_write  out  1  PC update enable.
REQ-012 if_id_write  out  1  IF_ID load enable.
REQ-013 if_id_flush  out  1  IF_ID loads all-zero NOP; overrides if_id_write.
REQ-014 id_ex_bubble  out  1  ID_EX control fields forced to zero.
REQ-015 state  out  2  current FSM state, for debug.

Function
REQ-016 The FSM SHALL have states RUN=0, FLUSH=1, IWAIT=2; encoding 3 is illegal and SHALL return to RUN on the next clk.
REQ-017 Load-use hazard: lu = ex_mem_read AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-018 All outputs SHALL be combinational from state, counter and current inputs (same-cycle reaction); state and counter SHALL be registered.
REQ-019 Priority in every state: branch_taken > lu (RUN only) > NOT imem_ready > normal.
REQ-020 branch_taken, any state: pc_write=1, if_id_flush=1, id_ex_bubble=1; if BRANCH_PENALTY=1, next=RUN; else next=FLUSH with cnt=BRANCH_PENALTY-1.
REQ-021 RUN with lu: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0; stay RUN; imem_ready ignored this cycle.
REQ-022 RUN, no lu, imem_ready=0: pc_write=0, if_id_flush=1, id_ex_bubble=0; next=IWAIT.
REQ-023 Normal (RUN no event, or IWAIT with imem_ready=1): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0; next=RUN.
REQ-024 IWAIT with imem_ready=0: same outputs as REQ-022; stay IWAIT; lu suppressed (ID holds a NOP).
REQ-025 FLUSH without branch_taken: if_id_flush=1, id_ex_bubble=0, pc_write=imem_ready; lu suppressed; cnt decrements; at cnt==1 next=RUN.
REQ-026 branch_taken in FLUSH SHALL reload cnt (restart penalty), not extend it additively.
REQ-027 if_id_write SHALL be 1 whenever if_id_flush=1.

Reset
REQ-028 While rst_n=0: state=RUN, cnt=0, pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
REQ-029 Reset asserted mid-FLUSH or mid-IWAIT SHALL abandon the sequence; the first cycle after release behaves as RUN.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN: when defined, add output stall_cnt (32 bits), counting cycles with pc_write=0 or if_id_flush=1 while rst_n=1, saturating at 0xFFFFFFFF, reset to 0.
REQ-031 Without HAZARD_PERF_CNT_EN, port stall_cnt and its register SHALL NOT exist; all other behaviour is identical.

Verification
REQ-032 ex_mem_read=1, ex_rt=8, id_rs=8, imem_ready=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; state stays 0.
REQ-033 Same with ex_rt=0, id_rs=0 -> no stall (pc_write=1); also id_rt=8, id_uses_rt=0 -> no stall.
REQ-034 BRANCH_PENALTY=3, branch_taken pulse in cycle N -> if_id_flush=1 in N, N+1, N+2; id_ex_bubble=1 only in N; state=1 in N+1 and N+2, 0 in N+3.
REQ-035 imem_ready=0 for 4 cycles, then 1 -> pc_write=0 and if_id_flush=1 for 4 cycles, state=2 from the 2nd cycle; normal outputs on the ready cycle.
REQ-036 lu and imem_ready=0 together -> stall outputs (no flush); branch_taken plus lu -> branch outputs win.
REQ-037 rst_n pulsed low during FLUSH (BRANCH_PENALTY=5) -> state=0 immediately; with HAZARD_PERF_CNT_EN, stall_cnt=0 after reset and equals the number of stall/flush cycles in REQ-035 (4).
